// File: rtl/ram_cmd_master.sv
// ---------------------------------------------------------------------------
// ram_cmd_master
//
// Turns single host read/write requests into a short sequence of command
// words for a RAM that takes its address, data and read trigger over one
// command bus, then returns a one-cycle response to the host.
//
// Command word cmd_din = {opcode[1:0], payload[ADDR_SIZE-1:0]}:
//   00 : write address      01 : write data
//   10 : read address       11 : read trigger (payload 0)
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   req_valid/ready : host request handshake (ready only while idle)
//   req_wr          : 1 = write, 0 = read
//   req_addr        : RAM address
//   req_wdata       : write data
//   rsp_valid       : one-cycle response pulse
//   rsp_rdata       : read data (0 for writes and timeouts)
//   rsp_err         : read timed out, qualified by rsp_valid
//   cmd_din         : command word to the RAM
//   cmd_valid       : command word strobe, one cycle per word
//   ram_dout        : RAM read data
//   ram_tx_valid    : RAM read data valid (only looked at while waiting)
//
// Parameters
//   ADDR_SIZE       : payload width of the command word
//   TIMEOUT_CYCLES  : wait cycles allowed for read data before an error
//
// Build option
//   RAM_CMD_ADDR_CACHE_EN : remember the last write and last read address;
//                           a request to the same address skips re-sending
//                           the address word.
// ---------------------------------------------------------------------------
module ram_cmd_master #(
    parameter int ADDR_SIZE      = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [ADDR_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [ADDR_SIZE-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [ADDR_SIZE+1:0] cmd_din,
    output logic                 cmd_valid,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    input  logic                 ram_tx_valid
);

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_CMD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_CMD,
        RD_WAIT,
        RESP
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ADDR_SIZE+1:0] cmd_din_nxt;
    logic                 cmd_valid_nxt;
    logic                 rsp_valid_nxt;
    logic [ADDR_SIZE-1:0] rsp_rdata_nxt;
    logic                 rsp_err_nxt;
    logic [CNT_W-1:0]     tmo_cnt;
    logic [CNT_W-1:0]     tmo_cnt_nxt;
    logic [ADDR_SIZE-1:0] wdata_q;
    logic                 accept;
    logic                 wr_hit;
    logic                 rd_hit;

    assign accept = req_valid && req_ready;

    // Write data is only sent one cycle after accept, so hold it here.
    always_ff @(posedge clk) begin
        if (accept && req_wr) begin
            wdata_q <= req_wdata;
        end
    end

`ifdef RAM_CMD_ADDR_CACHE_EN
    // ---- address cache: last address sent for each direction ----
    logic [ADDR_SIZE-1:0] wr_addr_c;
    logic [ADDR_SIZE-1:0] rd_addr_c;
    logic                 wr_addr_c_vld;
    logic                 rd_addr_c_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_c_vld <= 1'b0;
            rd_addr_c_vld <= 1'b0;
        end else if (accept) begin
            if (req_wr) begin
                wr_addr_c_vld <= 1'b1;
            end else begin
                rd_addr_c_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            if (req_wr) begin
                wr_addr_c <= req_addr;
            end else begin
                rd_addr_c <= req_addr;
            end
        end
    end

    assign wr_hit = wr_addr_c_vld && (wr_addr_c == req_addr);
    assign rd_hit = rd_addr_c_vld && (rd_addr_c == req_addr);
`else
    assign wr_hit = 1'b0;
    assign rd_hit = 1'b0;
`endif

    // ---- next-state and next-output logic ----
    always_comb begin
        state_nxt     = state;
        cmd_din_nxt   = cmd_din;
        cmd_valid_nxt = 1'b0;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        tmo_cnt_nxt   = tmo_cnt;

        case (state)
            IDLE: begin
                if (accept) begin
                    cmd_valid_nxt = 1'b1;
                    if (req_wr) begin
                        if (wr_hit) begin
                            state_nxt   = WR_DATA;
                            cmd_din_nxt = {OP_WR_DATA, req_wdata};
                        end else begin
                            state_nxt   = WR_ADDR;
                            cmd_din_nxt = {OP_WR_ADDR, req_addr};
                        end
                    end else begin
                        if (rd_hit) begin
                            state_nxt   = RD_CMD;
                            cmd_din_nxt = {OP_RD_CMD, {ADDR_SIZE{1'b0}}};
                        end else begin
                            state_nxt   = RD_ADDR;
                            cmd_din_nxt = {OP_RD_ADDR, req_addr};
                        end
                    end
                end
            end
            WR_ADDR: begin
                state_nxt     = WR_DATA;
                cmd_valid_nxt = 1'b1;
                cmd_din_nxt   = {OP_WR_DATA, wdata_q};
            end
            WR_DATA: begin
                state_nxt     = RESP;
                rsp_valid_nxt = 1'b1;
                rsp_rdata_nxt = '0;
                rsp_err_nxt   = 1'b0;
            end
            RD_ADDR: begin
                state_nxt     = RD_CMD;
                cmd_valid_nxt = 1'b1;
                cmd_din_nxt   = {OP_RD_CMD, {ADDR_SIZE{1'b0}}};
            end
            RD_CMD: begin
                state_nxt   = RD_WAIT;
                tmo_cnt_nxt = '0;
            end
            RD_WAIT: begin
                if (ram_tx_valid) begin
                    state_nxt     = RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = ram_dout;
                    rsp_err_nxt   = 1'b0;
                    tmo_cnt_nxt   = '0;
                end else if (tmo_cnt == CNT_LAST) begin
                    // This was the last allowed wait cycle.
                    state_nxt     = RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b1;
                    tmo_cnt_nxt   = '0;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---- state and output registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            cmd_din   <= '0;
            cmd_valid <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            req_ready <= (state_nxt == IDLE);
            cmd_din   <= cmd_din_nxt;
            cmd_valid <= cmd_valid_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_ram_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_ram_cmd_master
//
// Bench for ram_cmd_master with a behavioural RAM on the command bus and a
// transaction-level reference model that predicts command words, response
// latency (edges from accept to the edge that samples rsp_valid), data and
// error flag for each request.
// ---------------------------------------------------------------------------
module tb_ram_cmd_master;

    localparam int AW = 8;
    localparam int T  = 15;
`ifdef RAM_CMD_ADDR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] req_wdata;
    logic          rsp_valid;
    logic [AW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW+1:0] cmd_din;
    logic          cmd_valid;
    logic [AW-1:0] ram_dout = '0;
    logic          ram_tx_valid = 1'b0;

    int errors = 0;
    int checks = 0;

    ram_cmd_master #(.ADDR_SIZE(AW), .TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .cmd_din      (cmd_din),
        .cmd_valid    (cmd_valid),
        .ram_dout     (ram_dout),
        .ram_tx_valid (ram_tx_valid)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: decodes command words, answers read triggers after
    // rd_delay cycles (1 = ordinary single-cycle RAM), or never when mute.
    logic [AW-1:0] mem [0:255];
    logic [AW-1:0] ram_waddr = '0;
    logic [AW-1:0] ram_raddr = '0;
    int            pend = 0;
    bit            mute = 1'b0;
    bit            stuck = 1'b0;
    int            rd_delay = 1;

    always @(posedge clk) begin
        ram_tx_valid <= stuck;
        if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                ram_tx_valid <= 1'b1;
                ram_dout     <= mem[ram_raddr];
            end
        end
        if (rst) begin
            pend <= 0;
        end else if (cmd_valid) begin
            case (cmd_din[AW+1:AW])
                2'b00: ram_waddr <= cmd_din[AW-1:0];
                2'b01: mem[ram_waddr] <= cmd_din[AW-1:0];
                2'b10: ram_raddr <= cmd_din[AW-1:0];
                default: begin
                    if (!mute) begin
                        if (rd_delay == 1) begin
                            ram_tx_valid <= 1'b1;
                            ram_dout     <= mem[ram_raddr];
                        end else begin
                            pend <= rd_delay - 1;
                        end
                    end
                end
            endcase
        end
    end

    // Monitor: command words with their cycle index, and response pulses.
    int            cyc = 0;
    int            rsp_count = 0;
    logic [AW+1:0] cmd_q [$];
    int            cmd_cyc_q [$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (cmd_valid) begin
            cmd_q.push_back(cmd_din);
            cmd_cyc_q.push_back(cyc);
        end
        if (rsp_valid) begin
            rsp_count <= rsp_count + 1;
        end
    end

    // Reference model state: RAM contents as written by the host, and the
    // address each direction last sent (for the optional cache).
    logic [AW-1:0] ref_mem [int];
    bit            m_wr_vld = 1'b0;
    bit            m_rd_vld = 1'b0;
    logic [AW-1:0] m_wr_addr = '0;
    logic [AW-1:0] m_rd_addr = '0;

    task automatic model_reset();
        m_wr_vld = 1'b0;
        m_rd_vld = 1'b0;
    endtask

    task automatic run_txn(input string tag, input bit wr, input logic [AW-1:0] addr,
                           input logic [AW-1:0] wdata, input int delay, input bit no_data);
        logic [AW+1:0] exp_cmds [$];
        int            exp_lat;
        logic [AW-1:0] exp_rdata;
        bit            exp_err;
        bit            hit;
        int            base;
        int            lat;
        int            waited;

        hit  = wr ? (CACHE && m_wr_vld && m_wr_addr == addr)
                  : (CACHE && m_rd_vld && m_rd_addr == addr);
        base = hit ? 2 : 3;
        if (wr) begin
            if (!hit) exp_cmds.push_back({2'b00, addr});
            exp_cmds.push_back({2'b01, wdata});
            exp_lat   = base;
            exp_rdata = '0;
            exp_err   = 1'b0;
            ref_mem[int'(addr)] = wdata;
            m_wr_vld  = 1'b1;
            m_wr_addr = addr;
        end else begin
            if (!hit) exp_cmds.push_back({2'b10, addr});
            exp_cmds.push_back({2'b11, {AW{1'b0}}});
            if (!no_data && delay <= T) begin
                exp_lat   = base + delay;
                exp_rdata = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : '0;
                exp_err   = 1'b0;
            end else begin
                exp_lat   = base + T;
                exp_rdata = '0;
                exp_err   = 1'b1;
            end
            m_rd_vld  = 1'b1;
            m_rd_addr = addr;
        end

        mute     = no_data;
        rd_delay = delay;

        waited = 0;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready: req_ready=%b required 1", tag, req_ready);
        end

        cmd_q.delete();
        cmd_cyc_q.delete();
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        // Junk on the request port while busy must be ignored.
        req_valid = 1'($urandom_range(0, 1));
        req_wr    = 1'($urandom_range(0, 1));
        req_addr  = 8'($urandom);
        req_wdata = 8'($urandom);

        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        req_valid = 1'b0;

        checks++;
        if (lat != exp_lat || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s latency: got %0d (rsp_valid=%b) required %0d", tag, lat, rsp_valid, exp_lat);
        end
        checks++;
        if (rsp_err !== exp_err) begin
            errors++;
            $display("FAIL %s rsp_err: got %b required %b", tag, rsp_err, exp_err);
        end
        checks++;
        if (rsp_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL %s rsp_rdata: got %h required %h", tag, rsp_rdata, exp_rdata);
        end
        checks++;
        if (cmd_q.size() != exp_cmds.size()) begin
            errors++;
            $display("FAIL %s cmd_count: got %0d required %0d", tag, cmd_q.size(), exp_cmds.size());
        end else begin
            for (int i = 0; i < exp_cmds.size(); i++) begin
                checks++;
                if (cmd_q[i] !== exp_cmds[i]) begin
                    errors++;
                    $display("FAIL %s cmd_din[%0d]: got %h required %h", tag, i, cmd_q[i], exp_cmds[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (cmd_cyc_q[i] != cmd_cyc_q[0] + i) begin
                        errors++;
                        $display("FAIL %s cmd_cycle[%0d]: got %0d required %0d", tag, i, cmd_cyc_q[i], cmd_cyc_q[0] + i);
                    end
                end
            end
        end

        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after_resp: rsp_valid=%b req_ready=%b required 0/1", tag, rsp_valid, req_ready);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (req_ready !== 1'b1 || cmd_valid !== 1'b0 || cmd_din !== '0 ||
            rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL %s: ready=%b cmd_valid=%b cmd_din=%h rsp_valid=%b rdata=%h err=%b required 1/0/000/0/00/0",
                     tag, req_ready, cmd_valid, cmd_din, rsp_valid, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        req_wr = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_outputs("reset_release");
    endtask

    task automatic test_write_basic();
        run_txn("write_3c", 1'b1, 8'h3C, 8'hA5, 1, 1'b0);
    endtask

    task automatic test_read_basic();
        run_txn("read_3c", 1'b0, 8'h3C, 8'h00, 1, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        int snap;
        mute = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 8'h22;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy: req_ready=%b required 0", req_ready);
        end
        snap = rsp_count;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        model_reset();
        repeat (T + 10) @(negedge clk);
        checks++;
        if (rsp_count != snap) begin
            errors++;
            $display("FAIL mid_no_rsp: responses %0d required %0d", rsp_count, snap);
        end
        mute = 1'b0;
    endtask

    task automatic test_timeout();
        run_txn("timeout", 1'b0, 8'h3C, 8'h00, 1, 1'b1);
        run_txn("delay_T", 1'b0, 8'h3C, 8'h00, T, 1'b0);
        run_txn("delay_T1", 1'b0, 8'h3C, 8'h00, T + 1, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_stale_valid();
        int snap;
        run_txn("stale_rd", 1'b0, 8'h3C, 8'h00, 1, 1'b0);
        stuck = 1'b1;
        @(negedge clk);
        snap = rsp_count;
        run_txn("stale_wr", 1'b1, 8'h51, 8'h6E, 1, 1'b0);
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (rsp_count != snap + 1) begin
            errors++;
            $display("FAIL stale_count: responses %0d required %0d", rsp_count - snap, 1);
        end
        stuck = 1'b0;
        repeat (2) @(negedge clk);
    endtask

`ifdef RAM_CMD_ADDR_CACHE_EN
    task automatic test_cache();
        run_txn("cache_wr1", 1'b1, 8'h10, 8'h5A, 1, 1'b0);
        run_txn("cache_wr2", 1'b1, 8'h10, 8'hC3, 1, 1'b0);
        run_txn("cache_rd1", 1'b0, 8'h10, 8'h00, 1, 1'b0);
        run_txn("cache_rd2", 1'b0, 8'h10, 8'h00, 2, 1'b0);
        run_txn("cache_wr3", 1'b1, 8'h11, 8'h0F, 1, 1'b0);
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            bit            wr;
            logic [AW-1:0] addr;
            int            r;
            int            d;
            bit            nd;
            wr   = 1'($urandom_range(0, 1));
            addr = 8'h40 + 8'($urandom_range(0, 3));
            r    = int'($urandom_range(0, 9));
            nd   = (r == 0);
            d    = (r == 1) ? T : (r == 2) ? T + 1 : int'($urandom_range(1, 3));
            run_txn($sformatf("rand%0d", n), wr, addr, 8'($urandom), d, nd);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_write_basic();
        test_read_basic();
        test_reset_mid_op();
        test_timeout();
        test_stale_valid();
`ifdef RAM_CMD_ADDR_CACHE_EN
        test_cache();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
